// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory address, buffers
// fetched words in a small in-order FIFO toward decode, and handles redirects.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        fetch_pc_r;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [31:0]        buf_pc_r    [BUF_DEPTH];
  logic [31:0]        buf_instr_r [BUF_DEPTH];
  logic               push_s;
  logic               pop_s;
  logic               misaligned_s;

  // Next-state and push/pop decisions; a redirect suppresses both push and pop.
  always_comb begin
    state_s      = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    misaligned_s = (redirect_pc[1:0] != 2'b00);
    case (state_r)
      BOOT:    state_s = RUN;
      RUN:     state_s = RUN;
      FAULT:   state_s = FAULT;
      default: state_s = BOOT;
    endcase
    if (redirect_valid) begin
      state_s = misaligned_s ? FAULT : RUN;
    end else begin
      pop_s  = if_valid && if_ready;
      push_s = (state_r == RUN) && ((count_r < DEPTH_C) || pop_s);
    end
  end

  // Control state: FSM, fetch PC, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= BOOT;
      fetch_pc_r <= RESET_PC;
      count_r    <= {CNT_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else if (redirect_valid) begin
      state_r    <= state_s;
      fetch_pc_r <= redirect_pc;
      count_r    <= {CNT_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r   <= wr_ptr_r + PTR_W'(1'b1);
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        wr_ptr_r   <= wr_ptr_r;
        fetch_pc_r <= fetch_pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage; contents are only meaningful where count covers them.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      buf_pc_r[wr_ptr_r]    <= fetch_pc_r;
      buf_instr_r[wr_ptr_r] <= imem_instr;
    end
  end

  assign imem_addr   = fetch_pc_r;
  assign if_valid    = (count_r != {CNT_W{1'b0}});
  // Empty buffer presents zeros rather than stale entries.
  assign if_pc       = if_valid ? buf_pc_r[rd_ptr_r]    : 32'h0000_0000;
  assign if_instr    = if_valid ? buf_instr_r[rd_ptr_r] : 32'h0000_0000;
  assign fetch_fault = (state_r == FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, fetch_fault;
  logic [31:0] if_instr, if_pc;

  logic        reset2;
  logic [31:0] imem_addr2, imem_instr2, if_instr2, if_pc2;
  logic        if_valid2, fetch_fault2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0031_00B3;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr  = mem(imem_addr);
  assign imem_instr2 = mem(imem_addr2);

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .fetch_fault(fetch_fault));

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .if_ready(1'b1), .fetch_fault(fetch_fault2));

  // Reference model: FIFO contents as a queue of {pc, instr} pairs.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_boot, m_fault, m_clean;
  localparam int DEPTH = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare current outputs to the model, advance the model by one edge, wait a cycle.
  task automatic step();
    bit   pop, push;
    ent_t e;
    chk("if_valid", {31'b0, if_valid}, {31'b0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end else if (m_clean) begin
      chk("if_pc_zero", if_pc, 32'h0000_0000);
      chk("if_instr_zero", if_instr, 32'h0000_0000);
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    if (reset) begin
      q.delete();
      m_pc = 32'h0000_0000; m_boot = 1'b1; m_fault = 1'b0; m_clean = 1'b1;
    end else if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc; m_boot = 1'b0; m_fault = (redirect_pc[1:0] != 2'b00);
    end else begin
      pop  = (q.size() != 0) && if_ready;
      push = !m_boot && !m_fault && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = m_pc; e.instr = mem(m_pc);
        q.push_back(e);
        m_pc = m_pc + 32'd4;
        m_clean = 1'b0;
      end
      m_boot = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp2;
    int r;
    reset = 1'b1; reset2 = 1'b1; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
    q.delete(); m_pc = 32'h0000_0000; m_boot = 1'b1; m_fault = 1'b0; m_clean = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();

    // Release reset, streaming fetch; second instance checks PC wrap from reset.
    reset = 1'b0; reset2 = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin
        chk("wrap_valid_early", {31'b0, if_valid2}, 32'd0);
      end else if (k < 5) begin
        exp2 = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        chk("wrap_valid", {31'b0, if_valid2}, 32'd1);
        chk("wrap_pc", if_pc2, exp2);
      end else begin
        chk("wrap_fault", {31'b0, fetch_fault2}, 32'd0);
      end
      if (k == 2) begin
        chk("first_pc", if_pc, 32'h0000_0000);
        chk("first_instr", if_instr, 32'h0031_00B3);
      end
      step();
    end

    // Stall: buffer fills and holds, then drains in order.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Redirect while full with decode ready.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Misaligned redirect faults; aligned redirect recovers.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if_ready = i[0];
      step();
    end
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Redirect near the top of the address space to see the PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Reset with a full buffer and a concurrent redirect.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    reset = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1;
    chk("rst_redirect_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      redirect_valid = (r < 6);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (r == 0) redirect_pc = redirect_pc | 32'h0000_0002;
      if (r == 1) redirect_pc = 32'hFFFF_FFF4;
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
